pwm_dac: RTL and testbench

PWM_DAC -- requirements
Module: pwm_dac

---
 rtl/sig_pkg.sv | 5 +
 rtl/pwm_channel.sv | 28 ++
 rtl/pwm_dac.sv | 85 ++++++++
 tb/tb_pwm_dac.sv | 113 +++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// sig_pkg: shared FSM state type and default sample width for the PWM DAC
package sig_pkg;
  localparam int D_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM lane with shadow sample, active duty, compare and output flop
//   clk, rst (sync, active-low), wr: write din into shadow, load: shadow -> duty,
//   run: compare enabled (else output forced low), cnt: period counter, pwm: registered output
module pwm_channel import sig_pkg::*; #(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               load,
  input  logic               run,
  input  logic [D_WIDTH-1:0] din,
  input  logic [D_WIDTH-1:0] cnt,
  output logic               pwm
);
  logic [D_WIDTH-1:0] shadow, duty;
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= '0;
      duty   <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wr) shadow <= din;
      if (load) duty <= shadow;
      pwm <= run && (cnt < duty);
    end
  end
endmodule

// File: rtl/pwm_dac.sv
// pwm_dac: two-channel PWM DAC with shadowed duty handshake, run/drain/idle control
//   clk, rst (sync, active-low), en: run request, din1/din2 + din_valid/din_ready: sample pair,
//   sample_req: period-start pulse, pwm1/pwm2: outputs, underrun: period began with empty shadow,
//   busy: not idle. Define PWM_CENTER_ALIGNED_EN for an up/down (center-aligned) counter.
module pwm_dac import sig_pkg::*; #(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din1,
  input  logic [D_WIDTH-1:0] din2,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               sample_req,
  output logic               pwm1,
  output logic               pwm2,
  output logic               underrun,
  output logic               busy
);
  localparam logic [D_WIDTH-1:0] MAX = '1;
  localparam logic [D_WIDTH-1:0] ONE = D_WIDTH'(1);
  state_t state, state_nxt;
  logic [D_WIDTH-1:0] cnt, cnt_nxt;
  logic shadow_full, boundary, xfer, load, run;
`ifdef PWM_CENTER_ALIGNED_EN
  logic down, down_nxt;
  // with MAX==1 there is no down-count phase, so the boundary falls on the up-count MAX
  always_comb begin
    boundary = state == IDLE ? en : (MAX == ONE ? cnt == MAX : down && cnt == ONE);
    down_nxt = down ? cnt != ONE : (cnt == MAX && MAX != ONE);
    cnt_nxt  = (down || cnt == MAX) ? cnt - ONE : cnt + ONE;
    if (state == IDLE || state_nxt == IDLE) begin
      down_nxt = 1'b0;
      cnt_nxt  = '0;
    end
  end
`else
  always_comb begin
    boundary = state == IDLE ? en : cnt == MAX;
    cnt_nxt  = (state == IDLE || state_nxt == IDLE) ? '0 : cnt + ONE;
  end
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = en ? RUN : IDLE;
      RUN:     state_nxt = en ? RUN : DRAIN;
      DRAIN:   state_nxt = en ? RUN : (boundary ? IDLE : DRAIN);
      default: state_nxt = IDLE;
    endcase
  end
  // a RUN boundary frees the shadow in the same edge, so a refill can land alongside the copy
  assign din_ready  = !shadow_full || (boundary && state == RUN);
  assign xfer       = din_valid && din_ready;
  assign load       = boundary && shadow_full;
  assign run        = state != IDLE && state_nxt != IDLE;
  assign sample_req = state == RUN && cnt == '0;
  assign busy       = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow_full <= 1'b0;
      underrun    <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      down        <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shadow_full <= xfer ? 1'b1 : (load ? 1'b0 : shadow_full);
      underrun    <= boundary && state_nxt == RUN && !shadow_full;
`ifdef PWM_CENTER_ALIGNED_EN
      down        <= down_nxt;
`endif
    end
  end
  pwm_channel #(.D_WIDTH(D_WIDTH)) u_ch1 (
    .clk(clk), .rst(rst), .wr(xfer), .load(load), .run(run), .din(din1), .cnt(cnt), .pwm(pwm1)
  );
  pwm_channel #(.D_WIDTH(D_WIDTH)) u_ch2 (
    .clk(clk), .rst(rst), .wr(xfer), .load(load), .run(run), .din(din2), .cnt(cnt), .pwm(pwm2)
  );
endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed self-checking bench for pwm_dac (edge-aligned build)
module tb_pwm_dac;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, din_valid = 1'b0;
  logic [W-1:0] din1 = '0, din2 = '0;
  logic din_ready, sample_req, pwm1, pwm2, underrun, busy;
  int errors = 0, checks = 0;
  int h1, h2, sr, ur;
  pwm_dac #(.D_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .din1(din1), .din2(din2), .din_valid(din_valid),
    .din_ready(din_ready), .sample_req(sample_req), .pwm1(pwm1), .pwm2(pwm2),
    .underrun(underrun), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic measure(output int a, output int b, output int s, output int u);
    a = 0; b = 0; s = 0; u = 0;
    repeat (256) begin
      a += int'(pwm1 === 1'b1); b += int'(pwm2 === 1'b1);
      s += int'(sample_req === 1'b1); u += int'(underrun === 1'b1);
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b0; en = 1'b1; din_valid = 1'b1; din1 = 8'hAA; din2 = 8'h55;
    repeat (3) @(negedge clk);
    checks++; if (pwm1 !== 1'b0) begin errors++; $display("FAIL reset_pwm1: got %b want 0", pwm1); end
    checks++; if (pwm2 !== 1'b0) begin errors++; $display("FAIL reset_pwm2: got %b want 0", pwm2); end
    checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL reset_sample_req: got %b want 0", sample_req); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
  endtask
  task automatic test_edge;
    rst = 1'b1; en = 1'b0; din1 = 8'd64; din2 = 8'd192; din_valid = 1'b1;
    @(negedge clk);
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL idle_shadow_full: got %b want 0", din_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL start_sample_req: got %b want 1", sample_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL start_underrun: got %b want 0", underrun); end
    repeat (256) @(negedge clk);
    measure(h1, h2, sr, ur);
    checks++; if (h1 != 64) begin errors++; $display("FAIL edge_pwm1_high: got %0d want 64", h1); end
    checks++; if (h2 != 192) begin errors++; $display("FAIL edge_pwm2_high: got %0d want 192", h2); end
    checks++; if (sr != 1) begin errors++; $display("FAIL edge_sample_req_count: got %0d want 1", sr); end
    checks++; if (ur != 0) begin errors++; $display("FAIL edge_underrun_count: got %0d want 0", ur); end
  endtask
  task automatic test_back_to_back;
    checks++; if (sample_req !== 1'b1) begin errors++; $display("FAIL b2b_period_start: got %b want 1", sample_req); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL b2b_midperiod_ready: got %b want 0", din_ready); end
    din1 = 8'd0; din2 = 8'd255;
    repeat (255) @(negedge clk);
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL b2b_boundary_ready: got %b want 1", din_ready); end
    @(negedge clk);
    measure(h1, h2, sr, ur);
    checks++; if (h1 != 64) begin errors++; $display("FAIL b2b_old_pwm1: got %0d want 64", h1); end
    checks++; if (h2 != 192) begin errors++; $display("FAIL b2b_old_pwm2: got %0d want 192", h2); end
  endtask
  task automatic test_extremes;
    measure(h1, h2, sr, ur);
    checks++; if (h1 != 0) begin errors++; $display("FAIL duty0_pwm1: got %0d want 0", h1); end
    checks++; if (h2 != 255) begin errors++; $display("FAIL dutymax_pwm2: got %0d want 255", h2); end
    checks++; if (sr != 1) begin errors++; $display("FAIL extremes_sample_req: got %0d want 1", sr); end
  endtask
  task automatic test_underrun;
    din1 = 8'd100; din2 = 8'd10; din_valid = 1'b0;
    measure(h1, h2, sr, ur);
    checks++; if (ur != 0) begin errors++; $display("FAIL ur_first_period: got %0d want 0", ur); end
    measure(h1, h2, sr, ur);
    checks++; if (ur != 0) begin errors++; $display("FAIL ur_second_period: got %0d want 0", ur); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse: got %b want 1", underrun); end
    din_valid = 1'b1;
    measure(h1, h2, sr, ur);
    checks++; if (ur != 1) begin errors++; $display("FAIL ur_pulse_count: got %0d want 1", ur); end
    checks++; if (h1 != 0) begin errors++; $display("FAIL ur_repeat_pwm1: got %0d want 0", h1); end
    checks++; if (h2 != 255) begin errors++; $display("FAIL ur_repeat_pwm2: got %0d want 255", h2); end
    measure(h1, h2, sr, ur);
    checks++; if (h1 != 100) begin errors++; $display("FAIL refill_pwm1: got %0d want 100", h1); end
    checks++; if (h2 != 10) begin errors++; $display("FAIL refill_pwm2: got %0d want 10", h2); end
    checks++; if (ur != 0) begin errors++; $display("FAIL refill_underrun: got %0d want 0", ur); end
  endtask
  task automatic test_stop;
    int b, s;
    repeat (100) @(negedge clk);
    en = 1'b0;
    b = 0; s = 0;
    repeat (155) begin
      @(negedge clk);
      b += int'(busy === 1'b1); s += int'(sample_req === 1'b1);
    end
    checks++; if (b != 155) begin errors++; $display("FAIL drain_busy_cycles: got %0d want 155", b); end
    checks++; if (s != 0) begin errors++; $display("FAIL drain_sample_req: got %0d want 0", s); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle_busy: got %b want 0", busy); end
    checks++; if (pwm1 !== 1'b0) begin errors++; $display("FAIL stop_pwm1: got %b want 0", pwm1); end
    @(negedge clk);
    checks++; if (pwm2 !== 1'b0) begin errors++; $display("FAIL stop_pwm2: got %b want 0", pwm2); end
    checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL stop_sample_req: got %b want 0", sample_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy_held: got %b want 0", busy); end
  endtask
  initial begin
    test_reset;
    test_edge;
    test_back_to_back;
    test_extremes;
    test_underrun;
    test_stop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
